// File: rtl/ext_intr_ctrl.sv
// External interrupt controller: synchronises peripheral interrupt lines,
// keeps level/edge pending bits, selects one source by fixed priority and
// runs the claim/complete handshake toward the machine-mode CSR block.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | nothing presented; waiting for an eligible source
// ST_PENDING | claim_id frozen, m_ext_intr_o asserted, awaiting claim
// ST_SERVICE | source claimed, busy_o asserted, awaiting completion
module ext_intr_ctrl #(
    parameter int NUM_SRC    = 8,
    parameter int CAUSE_BASE = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               cfg_we_i,
    input  logic               cfg_sel_i,
    input  logic [NUM_SRC-1:0] cfg_wdata_i,
    input  logic               int_read_i,
    input  logic               complete_i,
    output logic               m_ext_intr_o,
    output logic [30:0]        mcause_o,
    output logic [4:0]         claim_id_o,
    output logic               busy_o,
    output logic [NUM_SRC-1:0] pending_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t state_q, state_n;

    logic [NUM_SRC-1:0] s1_q, s2_q, s2_d_q;
    logic [NUM_SRC-1:0] enable_q, edge_q;
    logic [NUM_SRC-1:0] pending_n;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] mode_chg;
    logic [4:0]         winner;
    logic [4:0]         claim_n;
    logic               en_drop;
    logic               m_ext_n;
    logic               busy_n;
    logic [30:0]        mcause_n;

    assign eligible   = pending_o & enable_q;
    assign claim_mask = NUM_SRC'(1) << claim_id_o;
    assign rise       = s2_q & ~s2_d_q;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s2_d_q <= '0;
        end else begin
            s1_q   <= src_i;
            s2_q   <= s1_q;
            s2_d_q <= s2_q;
        end
    end

    // Configuration registers: sel 0 = enable mask, sel 1 = edge-mode mask
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q <= '0;
            edge_q   <= '0;
        end else if (cfg_we_i) begin
            if (cfg_sel_i) edge_q   <= cfg_wdata_i;
            else           enable_q <= cfg_wdata_i;
        end
    end

    // Next pending vector; a new edge wins over a simultaneous claim
    always_comb begin
        claim_clr = '0;
        mode_chg  = '0;
        if (state_q == ST_PENDING && int_read_i) claim_clr = claim_mask;
        if (cfg_we_i && cfg_sel_i)               mode_chg  = edge_q ^ cfg_wdata_i;
        pending_n = (edge_q & ((pending_o & ~claim_clr) | rise)) | (~edge_q & s2_q);
        pending_n = pending_n & ~mode_chg;
    end

    // Pending register
    always_ff @(posedge clk_i) begin
        if (rst_i) pending_o <= '0;
        else       pending_o <= pending_n;
    end

    // Fixed priority: lowest eligible index wins
    always_comb begin
        winner = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (eligible[k]) winner = 5'(k);
        end
    end

    // Next state, latched claim id and registered output values
    always_comb begin
        state_n = state_q;
        claim_n = claim_id_o;
        en_drop = cfg_we_i && !cfg_sel_i && ((cfg_wdata_i & claim_mask) == '0);
        case (state_q)
            ST_IDLE: begin
                if (eligible != '0) begin
                    claim_n = winner;
                    state_n = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (int_read_i)
                    state_n = ST_SERVICE;
                else if (en_drop || ((eligible & claim_mask) == '0))
                    state_n = ST_IDLE;
            end
            ST_SERVICE: begin
                if (complete_i) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        m_ext_n  = (state_n == ST_PENDING);
        busy_n   = (state_n == ST_SERVICE);
        mcause_n = 31'(CAUSE_BASE) + 31'(claim_n);
    end

    // State register and registered CSR-facing outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            claim_id_o   <= '0;
            m_ext_intr_o <= 1'b0;
            busy_o       <= 1'b0;
            mcause_o     <= 31'(CAUSE_BASE);
        end else begin
            state_q      <= state_n;
            claim_id_o   <= claim_n;
            m_ext_intr_o <= m_ext_n;
            busy_o       <= busy_n;
            mcause_o     <= mcause_n;
        end
    end

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// Directed testbench for ext_intr_ctrl with hand-computed expectations.
module tb_ext_intr_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  src_i;
    logic        cfg_we_i;
    logic        cfg_sel_i;
    logic [7:0]  cfg_wdata_i;
    logic        int_read_i;
    logic        complete_i;
    logic        m_ext_intr_o;
    logic [30:0] mcause_o;
    logic [4:0]  claim_id_o;
    logic        busy_o;
    logic [7:0]  pending_o;

    int n_checks = 0;
    int n_errors = 0;

    ext_intr_ctrl #(.NUM_SRC(8), .CAUSE_BASE(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .src_i        (src_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_sel_i    (cfg_sel_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .int_read_i   (int_read_i),
        .complete_i   (complete_i),
        .m_ext_intr_o (m_ext_intr_o),
        .mcause_o     (mcause_o),
        .claim_id_o   (claim_id_o),
        .busy_o       (busy_o),
        .pending_o    (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic cfg_write(input logic sel, input logic [7:0] data);
        cfg_we_i    = 1'b1;
        cfg_sel_i   = sel;
        cfg_wdata_i = data;
        tick();
        cfg_we_i    = 1'b0;
    endtask

    task automatic pulse_read();
        int_read_i = 1'b1;
        tick();
        int_read_i = 1'b0;
    endtask

    task automatic pulse_complete();
        complete_i = 1'b1;
        tick();
        complete_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; src_i = '0; cfg_we_i = 0; cfg_sel_i = 0; cfg_wdata_i = '0;
        int_read_i = 0; complete_i = 0;
        tick(2);
        check_val("rst_m_ext",   32'(m_ext_intr_o), 32'd0);
        check_val("rst_busy",    32'(busy_o),       32'd0);
        check_val("rst_claim",   32'(claim_id_o),   32'd0);
        check_val("rst_mcause",  32'(mcause_o),     32'd16);
        check_val("rst_pending", 32'(pending_o),    32'd0);
        rst_i = 1'b0;

        // Level source 0, one-cycle pulse: latency and release back to IDLE
        cfg_write(1'b0, 8'h01);
        src_i = 8'h01;
        tick();                       // edge N
        src_i = 8'h00;
        tick();                       // N+1
        check_val("lat_n1_m_ext", 32'(m_ext_intr_o), 32'd0);
        tick();                       // N+2
        check_val("lat_n2_pend",  32'(pending_o),    32'h01);
        check_val("lat_n2_m_ext", 32'(m_ext_intr_o), 32'd0);
        tick();                       // N+3
        check_val("lat_n3_m_ext", 32'(m_ext_intr_o), 32'd1);
        check_val("lat_mcause",   32'(mcause_o),     32'd16);
        check_val("lat_claim",    32'(claim_id_o),   32'd0);
        tick();                       // N+4: level released
        check_val("release_m_ext", 32'(m_ext_intr_o), 32'd0);

        // Priority between sources 5 and 2
        cfg_write(1'b0, 8'hFF);
        src_i = 8'h24;
        tick(4);
        check_val("prio_m_ext",  32'(m_ext_intr_o), 32'd1);
        check_val("prio_claim",  32'(claim_id_o),   32'd2);
        check_val("prio_mcause", 32'(mcause_o),     32'd18);
        pulse_read();
        check_val("prio_rd_m_ext", 32'(m_ext_intr_o), 32'd0);
        check_val("prio_rd_busy",  32'(busy_o),       32'd1);
        check_val("prio_rd_cause", 32'(mcause_o),     32'd18);
        src_i = 8'h20;
        tick(3);
        check_val("prio_svc_pend", 32'(pending_o), 32'h20);
        pulse_complete();
        check_val("prio_cpl_busy",  32'(busy_o),       32'd0);
        check_val("prio_cpl_m_ext", 32'(m_ext_intr_o), 32'd0);
        tick();
        check_val("src5_m_ext",  32'(m_ext_intr_o), 32'd1);
        check_val("src5_claim",  32'(claim_id_o),   32'd5);
        check_val("src5_mcause", 32'(mcause_o),     32'd21);
        pulse_read();
        src_i = 8'h00;
        tick(3);
        pulse_complete();
        check_val("src5_done_pend", 32'(pending_o), 32'h00);

        // Edge mode on source 3
        cfg_write(1'b1, 8'h08);
        src_i = 8'h08;
        tick();                       // N
        src_i = 8'h00;
        tick(2);                      // N+2
        check_val("edge_pend",   32'(pending_o),    32'h08);
        tick();                       // N+3
        check_val("edge_m_ext",  32'(m_ext_intr_o), 32'd1);
        check_val("edge_mcause", 32'(mcause_o),     32'd19);
        tick();
        check_val("edge_hold_m_ext", 32'(m_ext_intr_o), 32'd1);
        pulse_read();
        check_val("edge_clr_pend", 32'(pending_o), 32'h00);
        check_val("edge_clr_busy", 32'(busy_o),    32'd1);
        src_i = 8'h08;
        tick();
        src_i = 8'h00;
        tick(2);
        check_val("edge_svc_pend", 32'(pending_o), 32'h08);
        check_val("edge_svc_busy", 32'(busy_o),    32'd1);
        pulse_complete();
        check_val("edge_cpl_m_ext", 32'(m_ext_intr_o), 32'd0);
        tick();
        check_val("edge_re_m_ext", 32'(m_ext_intr_o), 32'd1);
        check_val("edge_re_claim", 32'(claim_id_o),   32'd3);
        pulse_read();
        pulse_complete();
        check_val("edge_idle_pend", 32'(pending_o), 32'h00);

        // Claim coinciding with a fresh edge on the same source
        src_i = 8'h08;
        tick();                       // N
        src_i = 8'h00;
        tick();                       // N+1
        src_i = 8'h08;
        tick();                       // N+2
        src_i = 8'h00;
        tick();                       // N+3
        check_val("race_m_ext", 32'(m_ext_intr_o), 32'd1);
        pulse_read();                 // N+4: claim and new edge together
        check_val("race_pend", 32'(pending_o), 32'h08);
        check_val("race_busy", 32'(busy_o),    32'd1);
        pulse_read();                 // read in SERVICE is ignored
        check_val("svc_read_busy",  32'(busy_o),       32'd1);
        check_val("svc_read_m_ext", 32'(m_ext_intr_o), 32'd0);
        check_val("svc_read_pend",  32'(pending_o),    32'h08);
        pulse_complete();
        tick();
        pulse_read();
        pulse_complete();
        check_val("race_done_pend", 32'(pending_o), 32'h00);

        // Disable while PENDING on level source 4
        src_i = 8'h10;
        tick(4);
        check_val("dis_m_ext",  32'(m_ext_intr_o), 32'd1);
        check_val("dis_claim",  32'(claim_id_o),   32'd4);
        check_val("dis_mcause", 32'(mcause_o),     32'd20);
        cfg_write(1'b0, 8'h00);
        check_val("dis_drop_m_ext", 32'(m_ext_intr_o), 32'd0);
        pulse_read();
        check_val("dis_read_busy", 32'(busy_o), 32'd0);
        src_i = 8'h00;
        tick(3);

        // Reset during SERVICE with pending = 0x0A
        cfg_write(1'b0, 8'hFF);
        cfg_write(1'b1, 8'h0A);
        src_i = 8'h0A;
        tick();
        src_i = 8'h00;
        tick(3);
        check_val("rs_claim", 32'(claim_id_o), 32'd1);
        pulse_read();
        check_val("rs_claim_pend", 32'(pending_o), 32'h08);
        src_i = 8'h02;
        tick();
        src_i = 8'h00;
        tick(2);
        check_val("rs_svc_pend", 32'(pending_o), 32'h0A);
        check_val("rs_svc_busy", 32'(busy_o),    32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_val("rs_m_ext",   32'(m_ext_intr_o), 32'd0);
        check_val("rs_busy",    32'(busy_o),       32'd0);
        check_val("rs_claim0",  32'(claim_id_o),   32'd0);
        check_val("rs_mcause",  32'(mcause_o),     32'd16);
        check_val("rs_pending", 32'(pending_o),    32'h00);
        src_i = 8'h01;
        tick(5);
        check_val("rs_en_pend",  32'(pending_o),    32'h01);
        check_val("rs_en_m_ext", 32'(m_ext_intr_o), 32'd0);
        src_i = 8'h00;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ext_intr_ctrl.md
# ext_intr_ctrl

External interrupt controller feeding the machine-mode CSR block. It collects up to `NUM_SRC` peripheral interrupt lines and synchronises them. It latches them as level- or edge-triggered pending bits, picks one by fixed priority, and presents a single machine external interrupt plus a stable cause code to the CSR. It then sequences the claim/complete handshake so that only one external source is in flight at a time.

## Interface
- `NUM_SRC`, 8 — number of interrupt sources, 1..31.
- `CAUSE_BASE`, 16 — cause code reported for source 0; source k reports `CAUSE_BASE + k`.

Ports:
- `clk_i` in 1 — single clock.
- `rst_i` in 1 — synchronous, active-high reset.
- `src_i` in NUM_SRC — raw asynchronous interrupt lines from peripherals.
- `cfg_we_i` in 1 — configuration write strobe.
- `cfg_sel_i` in 1 — selects the configuration register: 0 = enable mask, 1 = edge-mode mask (1 = edge, 0 = level).
- `cfg_wdata_i` in NUM_SRC — configuration write data, full overwrite.
- `int_read_i` in 1 — claim pulse from the CSR interrupt-entry read.
- `complete_i` in 1 — end-of-service pulse, driven by mret.
- `m_ext_intr_o` out 1 — machine external interrupt request to the CSR.
- `mcause_o` out 31 — cause code to the CSR, without the interrupt bit.
- `claim_id_o` out 5 — index of the selected or in-service source.
- `busy_o` out 1 — a source is claimed and not yet completed.
- `pending_o` out NUM_SRC — current pending vector, for debug and status.

## Operation

**Input synchronisation**
- Each `src_i` bit passes a 2-flop synchroniser giving `s2`.
- A delayed copy `s2_d` is kept for edge detection.

**Pending register**
- Level source: `pending[k] = s2[k]`, registered every cycle.
- Edge source:
  - Set on `s2 & ~s2_d`.
  - Cleared by a claim of k.
  - If a claim and a new edge for the same source occur in the same cycle, the edge wins and the bit stays set.
- Writing the edge-mode mask clears pending bits whose mode changes.

**Eligibility**
- `eligible = pending & enable`.
- Winner is the lowest eligible index (fixed priority, 0 highest).

**State machine**
- IDLE:
  - If eligible ≠ 0: latch winner into `claim_id`, go to PENDING.
  - Otherwise stay in IDLE.
- PENDING:
  - `m_ext_intr_o` = 1 and `claim_id` is frozen; a later higher-priority arrival does not preempt.
  - `int_read_i` → clear edge pending[claim_id], go to SERVICE.
  - Enable bit of `claim_id` cleared by a cfg write → go to IDLE with no claim.
  - Source's pending bit falls, as with a level source released → go to IDLE with no claim.
- SERVICE:
  - `m_ext_intr_o` = 0 and `busy_o` = 1; pending bits keep accumulating.
  - `complete_i` → go to IDLE.

**Outputs**
- `mcause_o = CAUSE_BASE + claim_id`, computed at 31-bit width with zero extension. It is stable throughout PENDING and SERVICE.
- `int_read_i` in IDLE or SERVICE, and `complete_i` in IDLE or PENDING, are ignored.
- `int_read_i` and `complete_i` asserted together in PENDING: the claim is taken and complete is ignored.
- Configuration writes take effect on the next edge and never disturb SERVICE.

## Timing
- All outputs are registered, with no combinational input→output path.
- Reset values:
  - `m_ext_intr_o` = 0, `busy_o` = 0, `claim_id_o` = 0.
  - `mcause_o = CAUSE_BASE`.
  - `pending_o` = 0; enable mask = 0; edge mask = 0 (all level); synchroniser flops = 0; state IDLE.
- Latency from `src_i` rise to `m_ext_intr_o`:
  - `src_i` high at edge N → s1 at N, s2 at N+1, pending at N+2, `m_ext_intr_o` = 1 after edge N+3.
- Claim: `int_read_i` high at edge M → after edge M, `m_ext_intr_o` = 0, `busy_o` = 1 and edge pending is cleared.
- Complete: `complete_i` high at edge C → IDLE after edge C. The next eligible source asserts `m_ext_intr_o` after edge C+1.
- Reset asserted mid-operation returns every register to its reset value on that edge. Any in-service claim is dropped.

## Test plan
- Reset, enable = 0x01, level, pulse `src_i[0]` high at edge 10 → `m_ext_intr_o` = 1 after edge 13, `mcause_o` = 16, `claim_id_o` = 0.
- Enable = 0xFF, raise `src_i[5]` and `src_i[2]` together → `claim_id_o` = 2, `mcause_o` = 18. After claim and complete, source 5 is served with `mcause_o` = 21.
- Edge mode on source 3: single 1-cycle pulse, then claim → pending[3] = 0, `busy_o` = 1. A second pulse during SERVICE re-sets pending[3]. After `complete_i`, `m_ext_intr_o` reasserts 2 cycles later.
- In PENDING for source 4, write enable = 0x00 → `m_ext_intr_o` = 0 next cycle and state IDLE. A later `int_read_i` has no effect (`busy_o` stays 0).
- Claim and a new edge on the same edge-mode source in the same cycle → pending stays 1. `int_read_i` while in SERVICE → ignored.
- Assert `rst_i` while in SERVICE with pending = 0x0A → all outputs return to reset values next cycle and `busy_o` = 0.
